// File: rtl/ir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ir_pkg
// Brief    : Shared FSM states, frame type and NEC timing defaults (50 MHz).
// Revision : 1.0 - initial release
// ============================================================================
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    EMIT  = 3'd4
  } ir_state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] cmd;
  } ir_frame_t;

  // Gap lengths between successive rising edges, in 50 MHz cycles
  localparam int unsigned NEC_CW         = 20;
  localparam int unsigned NEC_BIT_THRESH = 84375;
  localparam int unsigned NEC_BIT_MIN    = 40000;
  localparam int unsigned NEC_REPEAT_MIN = 500000;
  localparam int unsigned NEC_LEADER_MIN = 620000;
  localparam int unsigned NEC_TIMEOUT    = 750000;

  // Shift register layout is {~cmd, cmd, ~addr, addr}
  function automatic logic frame_ok(input logic [31:0] sr);
    return (sr[15:8] == ~sr[7:0]) && (sr[31:24] == ~sr[23:16]);
  endfunction

  function automatic ir_frame_t frame_of(input logic [31:0] sr);
    ir_frame_t f;
    f.addr = sr[7:0];
    f.cmd  = sr[23:16];
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_edge_timer.sv
`default_nettype none
// ============================================================================
// Module   : ir_edge_timer
// Brief    : IR input synchroniser, rising-edge detect and saturating gap timer.
// Revision : 1.0 - initial release
// ============================================================================
module ir_edge_timer
  import ir_pkg::*;
#(
  parameter int unsigned CW      = NEC_CW,
  parameter int unsigned TIMEOUT = NEC_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ir,
  output logic          rise,
  output logic [CW-1:0] gap
);

  localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);

  logic sync_a;
  logic sync_b;
  logic prev;

  assign rise = sync_b & ~prev;

  // Restarting at 1 makes gap equal the edge-to-edge spacing in cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      prev   <= 1'b0;
      gap    <= '0;
    end else begin
      sync_a <= ir;
      sync_b <= sync_a;
      prev   <= sync_b;
      if (rise) begin
        gap <= CW'(1);
      end else if (gap < C_TIMEOUT) begin
        gap <= gap + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ir_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ir_frame_ctrl
// Brief    : NEC IR frame receiver with complement check and valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module ir_frame_ctrl
  import ir_pkg::*;
#(
  parameter int unsigned CW         = NEC_CW,
  parameter int unsigned BIT_THRESH = NEC_BIT_THRESH,
  parameter int unsigned BIT_MIN    = NEC_BIT_MIN,
  parameter int unsigned REPEAT_MIN = NEC_REPEAT_MIN,
  parameter int unsigned LEADER_MIN = NEC_LEADER_MIN,
  parameter int unsigned TIMEOUT    = NEC_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ir,
  input  logic       ready,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       repeat_f,
  output logic       valid,
  output logic       err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [CW-1:0] C_BIT_THRESH = CW'(BIT_THRESH);
  localparam logic [CW-1:0] C_BIT_MIN    = CW'(BIT_MIN);
  localparam logic [CW-1:0] C_REPEAT_MIN = CW'(REPEAT_MIN);
  localparam logic [CW-1:0] C_LEADER_MIN = CW'(LEADER_MIN);
  localparam logic [CW-1:0] C_TIMEOUT    = CW'(TIMEOUT);

  ir_state_t     state;
  ir_state_t     state_nx;
  logic          rise;
  logic [CW-1:0] gap;
  logic          at_timeout;
  logic          bit_one;

  logic [4:0]    bitcnt;
  logic [31:0]   sr;
  ir_frame_t     last;
  logic          have_last;
  logic          rep_pend;

  logic          shift_en;
  logic          bit_clr;
  logic          set_last;
  logic          emit_rep;
  logic          emit_load;
  logic          ovr_set;
  logic          err_nx;

  ir_edge_timer #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_edge_timer (
    .clk   (clk),
    .reset (reset),
    .ir    (ir),
    .rise  (rise),
    .gap   (gap)
  );

  assign at_timeout = (gap >= C_TIMEOUT);
  assign bit_one    = (gap >= C_BIT_THRESH);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    shift_en  = 1'b0;
    bit_clr   = 1'b0;
    set_last  = 1'b0;
    emit_rep  = 1'b0;
    emit_load = 1'b0;
    ovr_set   = 1'b0;
    err_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) state_nx = LEAD;
      end
      LEAD: begin
        // A silent leader is just noise, so it times out without an error
        if (at_timeout) begin
          state_nx = IDLE;
        end else if (rise) begin
          if (gap >= C_LEADER_MIN) begin
            state_nx = DATA;
            bit_clr  = 1'b1;
          end else if (gap >= C_REPEAT_MIN) begin
            if (have_last) begin
              state_nx = EMIT;
              emit_rep = 1'b1;
            end else begin
              state_nx = IDLE;
              err_nx   = 1'b1;
            end
          end
        end
      end
      DATA: begin
        if (at_timeout) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end else if (rise) begin
          if (gap >= C_BIT_MIN && gap < C_REPEAT_MIN) begin
            shift_en = 1'b1;
            if (bitcnt == 5'd31) state_nx = CHECK;
          end else begin
            state_nx = IDLE;
            err_nx   = 1'b1;
          end
        end
      end
      CHECK: begin
        if (frame_ok(sr)) begin
          state_nx = EMIT;
          set_last = 1'b1;
        end else begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end
      end
      EMIT: begin
        state_nx = IDLE;
        // A transfer in this same cycle frees the output slot first
        if (!valid || ready) begin
          emit_load = 1'b1;
        end else begin
          ovr_set = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitcnt    <= '0;
      sr        <= '0;
      last      <= '0;
      have_last <= 1'b0;
      rep_pend  <= 1'b0;
      addr      <= '0;
      cmd       <= '0;
      repeat_f  <= 1'b0;
      valid     <= 1'b0;
      err       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      err <= err_nx;

      if (bit_clr) begin
        bitcnt <= '0;
      end else if (shift_en) begin
        bitcnt <= bitcnt + 5'd1;
      end

      // LSB-first reception: new bit enters at the top
      if (shift_en) sr <= {bit_one, sr[31:1]};

      if (err_nx) begin
        have_last <= 1'b0;
      end else if (set_last) begin
        have_last <= 1'b1;
        last      <= frame_of(sr);
      end

      if (set_last) begin
        rep_pend <= 1'b0;
      end else if (emit_rep) begin
        rep_pend <= 1'b1;
      end

      if (emit_load) begin
        addr     <= last.addr;
        cmd      <= last.cmd;
        repeat_f <= rep_pend;
        valid    <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      if (ovr_set) overrun <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ir_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_frame_ctrl
// Brief    : Directed and randomized bench for ir_frame_ctrl, timings scaled 1/2000.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_frame_ctrl;

  localparam int CW = 10, BIT_THRESH = 42, BIT_MIN = 20, REPEAT_MIN = 250;
  localparam int LEADER_MIN = 310, TIMEOUT = 375;
  localparam int PW = 4, TAIL = 8;
  localparam int G0 = 28, G1 = 56, GLEAD = 337, GREP = 281;

  logic       clk = 1'b0, rst_n = 1'b0, ir = 1'b0, ready = 1'b0;
  logic [7:0] addr, cmd;
  logic       repeat_f, valid, err, overrun, busy;

  ir_frame_ctrl #(
    .CW(CW), .BIT_THRESH(BIT_THRESH), .BIT_MIN(BIT_MIN),
    .REPEAT_MIN(REPEAT_MIN), .LEADER_MIN(LEADER_MIN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(rst_n), .ir(ir), .ready(ready),
    .addr(addr), .cmd(cmd), .repeat_f(repeat_f), .valid(valid),
    .err(err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  int cyc = 0, err_cycles = 0, last_err_cyc = -1, final_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (err === 1'b1) begin err_cycles = err_cycles + 1; last_err_cyc = cyc; end

  // Transaction-level expectation: output slot, last good frame, error count
  bit         m_valid = 0, m_rep = 0, m_ovr = 0, m_have = 0;
  logic [7:0] m_addr = 0, m_cmd = 0, m_la = 0, m_lc = 0;
  int         m_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_emit(input logic [7:0] a, input logic [7:0] c, input bit r);
    if (m_valid) m_ovr = 1;
    else begin m_valid = 1; m_addr = a; m_cmd = c; m_rep = r; end
  endtask

  task automatic model_err();
    m_err++;
    m_have = 0;
  endtask

  task automatic model_reset();
    m_valid = 0; m_rep = 0; m_ovr = 0; m_have = 0;
    m_addr = 0; m_cmd = 0; m_la = 0; m_lc = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".valid"},    32'(valid),    32'(m_valid));
    check_eq({tag, ".addr"},     32'(addr),     32'(m_addr));
    check_eq({tag, ".cmd"},      32'(cmd),      32'(m_cmd));
    check_eq({tag, ".repeat_f"}, 32'(repeat_f), 32'(m_rep));
    check_eq({tag, ".overrun"},  32'(overrun),  32'(m_ovr));
    check_eq({tag, ".busy"},     32'(busy),     32'd0);
    check_eq({tag, ".err_cnt"},  32'(err_cycles), 32'(m_err));
  endtask

  // Rising edge now, next rising edge exactly g cycles later
  task automatic pulse(input int g);
    @(negedge clk) ir = 1'b1;
    repeat (PW) @(negedge clk);
    ir = 1'b0;
    repeat (g - PW - 1) @(negedge clk);
  endtask

  // Last rising edge of a burst; rdy lands in the cycle the receiver emits
  task automatic finish_pulse(input int tail, input bit rdy);
    @(negedge clk) ir = 1'b1;
    final_cyc = cyc;
    repeat (PW) @(negedge clk);
    ir = 1'b0;
    ready = rdy;
    @(negedge clk) ready = 1'b0;
    repeat (tail) @(negedge clk);
  endtask

  function automatic int bit_gap(input bit b);
    int r;
    r = int'($urandom_range(0, 7));
    if (!b) return (r == 0) ? BIT_MIN : (r == 1) ? BIT_THRESH - 1 : int'($urandom_range(BIT_MIN, BIT_THRESH - 1));
    return (r == 0) ? BIT_THRESH : (r == 1) ? REPEAT_MIN - 1 : int'($urandom_range(BIT_THRESH, 80));
  endfunction

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [31:0] mask,
                            input bit rnd, input bit rdy, input bit pre);
    logic [31:0] w;
    w = {~c, c, ~a, a} ^ mask;
    if (pre) pulse(int'($urandom_range(10, REPEAT_MIN - 10)));
    pulse(rnd ? int'($urandom_range(LEADER_MIN, LEADER_MIN + 50)) : GLEAD);
    for (int i = 0; i < 32; i++) pulse(rnd ? bit_gap(w[i]) : (w[i] ? G1 : G0));
    finish_pulse(TAIL, rdy);
    if (rdy && m_valid) m_valid = 0;
    if (mask == 32'd0) begin m_have = 1; m_la = a; m_lc = c; model_emit(a, c, 1'b0); end
    else model_err();
  endtask

  task automatic send_repeat(input bit rnd);
    pulse(rnd ? int'($urandom_range(REPEAT_MIN, LEADER_MIN - 1)) : GREP);
    finish_pulse(TAIL, 1'b0);
    if (m_have) model_emit(m_la, m_lc, 1'b1);
    else model_err();
  endtask

  task automatic truncated(input int k);
    pulse(GLEAD);
    for (int i = 0; i < k; i++) pulse(bit_gap(1'($urandom_range(0, 1))));
    finish_pulse(TIMEOUT + 20, 1'b0);
    model_err();
  endtask

  task automatic bad_gap(input int k, input int g);
    pulse(GLEAD);
    for (int i = 0; i < k; i++) pulse(bit_gap(1'($urandom_range(0, 1))));
    pulse(g);
    finish_pulse(TAIL, 1'b0);
    model_err();
  endtask

  task automatic consume(input string tag);
    @(negedge clk) ready = 1'b1;
    @(negedge clk) ready = 1'b0;
    m_valid = 0;
    check_eq({tag, ".taken"}, 32'(valid), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst.addr", 32'(addr), 32'd0);
    check_eq("rst.cmd", 32'(cmd), 32'd0);
    check_eq("rst.repeat_f", 32'(repeat_f), 32'd0);
    check_eq("rst.valid", 32'(valid), 32'd0);
    check_eq("rst.err", 32'(err), 32'd0);
    check_eq("rst.overrun", 32'(overrun), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    send_frame(8'h04, 8'h1C, 32'd0, 1'b0, 1'b0, 1'b0);
    check_outputs("frame");
    consume("frame");
    send_repeat(1'b0);
    check_outputs("repeat");
    consume("repeat");

    send_frame(8'h04, 8'h1C, 32'h0700_0000, 1'b0, 1'b0, 1'b0);
    check_outputs("bad_cmp");
    check_eq("bad_cmp.err_lat", 32'(last_err_cyc - final_cyc), 32'd4);
    send_repeat(1'b0);
    check_outputs("rep_nolast");

    send_frame(8'h11, 8'h22, 32'd0, 1'b0, 1'b0, 1'b0);
    check_outputs("pend_a");
    send_frame(8'h33, 8'h44, 32'd0, 1'b0, 1'b1, 1'b0);
    check_outputs("coincide");
    send_frame(8'h55, 8'h66, 32'd0, 1'b0, 1'b0, 1'b0);
    check_outputs("overrun");

    truncated(10);
    check_outputs("timeout");
    bad_gap(5, 10);
    check_outputs("glitch");
    check_eq("glitch.err_lat", 32'(last_err_cyc - final_cyc), 32'd3);

    pulse(GLEAD);
    for (int i = 0; i < 17; i++) pulse(G1);
    check_eq("mid.busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid.addr", 32'(addr), 32'd0);
    check_eq("mid.cmd", 32'(cmd), 32'd0);
    check_eq("mid.repeat_f", 32'(repeat_f), 32'd0);
    check_eq("mid.valid", 32'(valid), 32'd0);
    check_eq("mid.overrun", 32'(overrun), 32'd0);
    check_eq("mid.busy_rst", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send_frame(8'hA5, 8'h3C, 32'd0, 1'b1, 1'b0, 1'b0);
    check_outputs("post_rst");

    for (int it = 0; it < 16; it++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: send_frame(8'($urandom), 8'($urandom), 32'd0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        4:          send_frame(8'($urandom), 8'($urandom), 32'd1 << $urandom_range(0, 31), 1'b1, 1'b0, 1'b0);
        5:          send_repeat(1'b1);
        6:          truncated(int'($urandom_range(0, 31)));
        7:          bad_gap(int'($urandom_range(0, 31)), int'($urandom_range(PW + 2, BIT_MIN - 1)));
        8:          finish_pulse(TIMEOUT + 20, 1'b0);
        default:    bad_gap(int'($urandom_range(0, 31)), int'($urandom_range(REPEAT_MIN, REPEAT_MIN + 50)));
      endcase
      check_outputs($sformatf("rnd%0d_t%0d", it, sel));
      if (m_valid && $urandom_range(0, 1) == 1) consume($sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
